vector_mem_responder: RTL and testbench



---
 rtl/vector_mem_responder_pkg.sv | 38 +++
 rtl/vector_mem_req_fifo.sv | 83 ++++++++
 rtl/vector_mem_responder.sv | 101 ++++++++++
 tb/tb_vector_mem_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_mem_responder_pkg
// Description : Shared request/response type, access encodings and widths
//               used by the vector memory responder and its request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_mem_responder_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int ADDR_WIDTH    = 32;
    localparam int BE_WIDTH      = DATA_WIDTH / 8;
    localparam int LEN_WIDTH     = 8;
    localparam int ID_WIDTH      = 8;
    localparam int CORE_ID_WIDTH = 4;

    // Access kinds; only READ_REQ and WRITE_REQ touch the memory array.
    typedef enum logic [1:0] {
        NOP_REQ   = 2'd0,
        READ_REQ  = 2'd1,
        WRITE_REQ = 2'd2,
        RSVD_REQ  = 2'd3
    } access_type_e;

    // Request and response share one layout so a response is a trimmed echo.
    typedef struct packed {
        logic                     vld;
        access_type_e             access_type;
        logic [LEN_WIDTH-1:0]     access_length;
        logic [ID_WIDTH-1:0]      access_id;
        logic [CORE_ID_WIDTH-1:0] core_id;
        logic [ADDR_WIDTH-1:0]    addr;
        logic [BE_WIDTH-1:0]      byte_en;
        logic [DATA_WIDTH-1:0]    data;
    } request_t;

endpackage : vector_mem_responder_pkg
`default_nettype wire

// File: rtl/vector_mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vector_mem_req_fifo
// Description : Power-of-two deep request queue holding full request_t
//               entries; pushes are refused while full, pops while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_mem_req_fifo
    import vector_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  request_t               push_data_i,
    input  logic                   pop_i,
    output request_t               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

    request_t          slots_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = slots_q[rd_ptr_q];

    // Full is judged on the current count, so a same-cycle pop never frees room.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are meaningless outside the valid window so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : vector_mem_req_fifo
`default_nettype wire

// File: rtl/vector_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : vector_mem_responder
// Description : Single-port vector memory model. Requests are queued, the
//               queue head is serviced every cycle against the backing array
//               and a registered response is issued one cycle after service.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_mem_responder
    import vector_mem_responder_pkg::*;
#(
    parameter int CORE_MEM_DEPTH = 1024,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  request_t mem_req,
    output logic     req_grant,
    output request_t mem_rsp,
    output logic     busy
);

    localparam int MEM_AW = $clog2(CORE_MEM_DEPTH);
    localparam int CNT_W  = $clog2(REQ_FIFO_DEPTH) + 1;

    request_t               head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   pop;
    logic [MEM_AW-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0]  mem_q [CORE_MEM_DEPTH];
    request_t               rsp_q, rsp_d;
    logic                   unused_head_bits;

    // Grant is purely combinational so the initiator sees it in the same cycle.
    assign req_grant = mem_req.vld && !reset && !fifo_full;

    // Nothing is serviced while reset is held, so queued work is silently dropped.
    assign pop = !fifo_empty && !reset;

    // Upper address bits alias onto the array (wrap-around addressing).
    assign mem_idx          = head.addr[MEM_AW-1:0];
    assign unused_head_bits = ^{head.addr[ADDR_WIDTH-1:MEM_AW], head.vld};

    vector_mem_req_fifo #(
        .DEPTH       (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (req_grant),
        .push_data_i (mem_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Byte-lane write of a serviced WRITE_REQ; the array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (pop && (head.access_type == WRITE_REQ)) begin
            for (int b = 0; b < BE_WIDTH; b++) begin
                if (head.byte_en[b]) begin
                    mem_q[mem_idx][b*8 +: 8] <= head.data[b*8 +: 8];
                end
            end
        end
    end

    // Build the response for the head being serviced; the read sees all earlier writes.
    always_comb begin
        rsp_d = '0;
        if (pop) begin
            rsp_d.vld           = 1'b1;
            rsp_d.access_type   = head.access_type;
            rsp_d.access_length = head.access_length;
            rsp_d.access_id     = head.access_id;
            rsp_d.core_id       = head.core_id;
            rsp_d.addr          = head.addr;
            if (head.access_type == READ_REQ) begin
                rsp_d.data = mem_q[mem_idx];
            end
        end
    end

    // Response register; all-zero whenever no request was serviced.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_q <= '0;
        end else begin
            rsp_q <= rsp_d;
        end
    end

    // Outputs are forced quiet during reset, including its first cycle.
    assign mem_rsp = reset ? '0 : rsp_q;
    assign busy    = !reset && ((fifo_count != '0) || rsp_q.vld);

endmodule : vector_mem_responder
`default_nettype wire

// File: tb/tb_vector_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_mem_responder
// Description : Randomized and directed bench for vector_mem_responder with a
//               queue-based reference model of the memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_mem_responder;
    import vector_mem_responder_pkg::*;

    localparam int CORE_D = 1024;
    localparam int FIFO_D = 4;

    logic     clk;
    logic     reset;
    request_t mem_req;
    logic     req_grant;
    request_t mem_rsp;
    logic     busy;

    vector_mem_responder #(
        .CORE_MEM_DEPTH (CORE_D),
        .REQ_FIFO_DEPTH (FIFO_D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .req_grant (req_grant),
        .mem_rsp   (mem_rsp),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int       cyc;
        request_t r;
    } log_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    request_t    mq[$];
    request_t    mdl_rsp = '0;
    logic [63:0] mdl_mem [CORE_D];
    log_t        rsp_log[$];

    function automatic logic [63:0] init_word(input int i);
        return 64'hC0DE_0000_1357_9BDF ^ {16'h0, 16'(i), 32'(i)};
    endfunction

    // Reference: service one request against the model memory, return its response.
    function automatic request_t model_service(input request_t h);
        request_t r;
        int       idx;
        r   = '0;
        idx = int'(h.addr % CORE_D);
        r.vld           = 1'b1;
        r.access_type   = h.access_type;
        r.access_length = h.access_length;
        r.access_id     = h.access_id;
        r.core_id       = h.core_id;
        r.addr          = h.addr;
        if (h.access_type == READ_REQ) begin
            r.data = mdl_mem[idx];
        end else if (h.access_type == WRITE_REQ) begin
            for (int b = 0; b < 8; b++) begin
                if (h.byte_en[b]) mdl_mem[idx][b*8 +: 8] = h.data[b*8 +: 8];
            end
        end
        return r;
    endfunction

    task automatic drive(input logic v, input access_type_e t, input logic [31:0] a,
                         input logic [7:0] be, input logic [63:0] d, input logic [7:0] id);
        mem_req               = '0;
        mem_req.vld           = v;
        mem_req.access_type   = t;
        mem_req.access_length = 8'd1;
        mem_req.access_id     = id;
        mem_req.core_id       = id[3:0];
        mem_req.addr          = a;
        mem_req.byte_en       = be;
        mem_req.data          = d;
    endtask

    task automatic idle();
        mem_req = '0;
    endtask

    // One clock cycle: compare outputs to the model in the low phase, then advance both.
    task automatic step();
        logic     exp_grant;
        logic     exp_busy;
        request_t exp_out;
        log_t     e;
        #1;
        exp_grant = mem_req.vld && !reset && (mq.size() < FIFO_D);
        exp_out   = reset ? '0 : mdl_rsp;
        exp_busy  = !reset && ((mq.size() != 0) || mdl_rsp.vld);
        total++;
        if (req_grant !== exp_grant) begin
            bad++;
            $display("FAIL grant cyc=%0d got=%b want=%b", cyc, req_grant, exp_grant);
        end
        total++;
        if (mem_rsp !== exp_out) begin
            bad++;
            $display("FAIL mem_rsp cyc=%0d got=%h want=%h", cyc, mem_rsp, exp_out);
        end
        total++;
        if (busy !== exp_busy) begin
            bad++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
        end
        if (mem_rsp.vld === 1'b1) begin
            e.cyc = cyc;
            e.r   = mem_rsp;
            rsp_log.push_back(e);
        end
        if (reset) begin
            mq.delete();
            mdl_rsp = '0;
        end else begin
            if (mq.size() != 0) mdl_rsp = model_service(mq.pop_front());
            else                mdl_rsp = '0;
            if (exp_grant) mq.push_back(mem_req);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        idle();
        while (((mq.size() != 0) || mdl_rsp.vld) && (n < limit)) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, READ_REQ, 32'(i), 8'hff, 64'h0, 8'(i));
            step();
        end
        reset = 1'b0;
    endtask

    task automatic test_init();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, WRITE_REQ, 32'(i), 8'hff, init_word(i), 8'(i));
            step();
        end
        drain(10);
    endtask

    task automatic test_raw();
        int c0;
        rsp_log.delete();
        c0 = cyc;
        drive(1'b1, WRITE_REQ, 32'd5, 8'hff, 64'hA5A5, 8'd10);
        step();
        drive(1'b1, READ_REQ, 32'd5, 8'h00, 64'h0, 8'd11);
        step();
        drain(10);
        total++;
        if (rsp_log.size() != 2) begin
            bad++;
            $display("FAIL raw_count got=%0d want=2", rsp_log.size());
        end else begin
            total++;
            if (rsp_log[0].cyc != c0 + 2) begin
                bad++; $display("FAIL raw_lat0 got=%0d want=%0d", rsp_log[0].cyc, c0 + 2);
            end
            total++;
            if (rsp_log[1].cyc != c0 + 3) begin
                bad++; $display("FAIL raw_lat1 got=%0d want=%0d", rsp_log[1].cyc, c0 + 3);
            end
            total++;
            if (rsp_log[1].r.data !== 64'hA5A5) begin
                bad++; $display("FAIL raw_data got=%h want=%h", rsp_log[1].r.data, 64'hA5A5);
            end
            total++;
            if (rsp_log[0].r.access_id !== 8'd10 || rsp_log[1].r.access_id !== 8'd11) begin
                bad++; $display("FAIL raw_ids got=%0d,%0d want=10,11",
                                rsp_log[0].r.access_id, rsp_log[1].r.access_id);
            end
            total++;
            if (rsp_log[0].r.data !== 64'h0) begin
                bad++; $display("FAIL raw_wdata got=%h want=0", rsp_log[0].r.data);
            end
        end
    endtask

    task automatic test_byte_en();
        rsp_log.delete();
        drive(1'b1, WRITE_REQ, 32'd7, 8'hff, {64{1'b1}}, 8'd12);
        step();
        drive(1'b1, WRITE_REQ, 32'd7, 8'h01, 64'h0, 8'd13);
        step();
        drive(1'b1, READ_REQ, 32'd7, 8'h00, 64'h0, 8'd14);
        step();
        drain(10);
        total++;
        if (rsp_log.size() != 3) begin
            bad++;
            $display("FAIL be_count got=%0d want=3", rsp_log.size());
        end else begin
            total++;
            if (rsp_log[2].r.data !== 64'hFFFF_FFFF_FFFF_FF00) begin
                bad++; $display("FAIL be_data got=%h want=%h", rsp_log[2].r.data,
                                64'hFFFF_FFFF_FFFF_FF00);
            end
        end
    endtask

    task automatic test_stall();
        rsp_log.delete();
        idle();
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, READ_REQ, 32'(i), 8'h00, 64'h0, 8'(20 + i));
            step();
        end
        drain(10);
        total++;
        if (rsp_log.size() != 6) begin
            bad++;
            $display("FAIL stall_count got=%0d want=6", rsp_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (rsp_log[i].r.access_id !== 8'(20 + i)) begin
                    bad++; $display("FAIL stall_order idx=%0d got=%0d want=%0d",
                                    i, rsp_log[i].r.access_id, 20 + i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_log.delete();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, READ_REQ, 32'(i % 16), 8'h00, 64'h0, 8'(i));
            step();
        end
        drain(10);
        total++;
        if (rsp_log.size() != 64) begin
            bad++;
            $display("FAIL burst_count got=%0d want=64", rsp_log.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                total++;
                if (rsp_log[i].r.access_id !== 8'(i)) begin
                    bad++; $display("FAIL burst_order idx=%0d got=%0d want=%0d",
                                    i, rsp_log[i].r.access_id, i);
                end
            end
        end
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL burst_busy got=%b want=0", busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, WRITE_REQ, 32'd9, 8'hff, 64'h1234_5678_9ABC_DEF0, 8'd30);
        step();
        drain(10);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, READ_REQ, 32'd9, 8'h00, 64'h0, 8'(31 + i));
            step();
        end
        rsp_log.delete();
        idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (rsp_log.size() != 0) begin
            bad++; $display("FAIL rst_discard got=%0d responses want=0", rsp_log.size());
        end
        drive(1'b1, READ_REQ, 32'd9, 8'h00, 64'h0, 8'd34);
        step();
        drain(10);
        total++;
        if (rsp_log.size() != 1) begin
            bad++; $display("FAIL rst_read_count got=%0d want=1", rsp_log.size());
        end else begin
            total++;
            if (rsp_log[0].r.data !== 64'h1234_5678_9ABC_DEF0) begin
                bad++; $display("FAIL rst_mem_kept got=%h want=%h", rsp_log[0].r.data,
                                64'h1234_5678_9ABC_DEF0);
            end
        end
    endtask

    task automatic test_wrap_invalid();
        rsp_log.delete();
        drive(1'b1, READ_REQ, 32'(CORE_D + 3), 8'h00, 64'h0, 8'd40);
        step();
        drive(1'b1, NOP_REQ, 32'd3, 8'hff, {64{1'b1}}, 8'd41);
        step();
        drive(1'b1, RSVD_REQ, 32'd3, 8'hff, {64{1'b1}}, 8'd42);
        step();
        drive(1'b1, READ_REQ, 32'd3, 8'h00, 64'h0, 8'd43);
        step();
        drain(10);
        total++;
        if (rsp_log.size() != 4) begin
            bad++; $display("FAIL wrap_count got=%0d want=4", rsp_log.size());
        end else begin
            total++;
            if (rsp_log[0].r.data !== init_word(3)) begin
                bad++; $display("FAIL wrap_data got=%h want=%h", rsp_log[0].r.data, init_word(3));
            end
            total++;
            if (rsp_log[0].r.addr !== 32'(CORE_D + 3)) begin
                bad++; $display("FAIL wrap_addr got=%h want=%h", rsp_log[0].r.addr, CORE_D + 3);
            end
            total++;
            if (rsp_log[1].r.data !== 64'h0 || rsp_log[2].r.data !== 64'h0) begin
                bad++; $display("FAIL inval_data got=%h,%h want=0,0",
                                rsp_log[1].r.data, rsp_log[2].r.data);
            end
            total++;
            if (rsp_log[2].r.access_type !== RSVD_REQ || rsp_log[2].r.access_id !== 8'd42) begin
                bad++; $display("FAIL inval_echo got=%0d/%0d want=3/42",
                                rsp_log[2].r.access_type, rsp_log[2].r.access_id);
            end
            total++;
            if (rsp_log[3].r.data !== init_word(3)) begin
                bad++; $display("FAIL inval_mem got=%h want=%h", rsp_log[3].r.data, init_word(3));
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) != 0,
                  access_type_e'($urandom_range(0, 3)),
                  32'($urandom_range(0, 15)) + (32'($urandom_range(0, 7)) << 10),
                  8'($urandom), {$urandom, $urandom}, 8'($urandom));
            step();
        end
        reset = 1'b0;
        drain(10);
        step();
    endtask

    initial begin
        reset   = 1'b1;
        mem_req = '0;
        for (int i = 0; i < CORE_D; i++) mdl_mem[i] = '0;
        test_reset();
        test_init();
        test_raw();
        test_byte_en();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_wrap_invalid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vector_mem_responder
`default_nettype wire
